// File: rtl/ctrl_pkg.sv
// Shared types, opcode map, control-vector layout and decode helpers
// for the ctrl_sequencer instruction step machine.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    I_LD, I_LDI, I_ST, I_ALU, I_MULDIV, I_BR, I_HALT, I_ILL
  } instr_t;

  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_MUL  = 7;
  localparam int unsigned OP_DIV  = 8;
  localparam int unsigned OP_BR   = 9;
  localparam int unsigned OP_HALT = 10;

  // bus_src bit positions; inport, lo and hi (5..7) are never driven here
  localparam int BUS_W = 9;
  localparam int B_PC  = 0;
  localparam int B_ZLO = 1;
  localparam int B_ZHI = 2;
  localparam int B_MDR = 3;
  localparam int B_C   = 4;
  localparam int B_R   = 8;

  localparam int LD_W  = 10;
  localparam int L_MAR = 0;
  localparam int L_PC  = 1;
  localparam int L_MDR = 2;
  localparam int L_IR  = 3;
  localparam int L_Y   = 4;
  localparam int L_Z   = 5;
  localparam int L_HI  = 6;
  localparam int L_LO  = 7;
  localparam int L_R   = 8;
  localparam int L_CON = 9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;

  typedef struct packed {
    logic [BUS_W-1:0] bus_src;
    logic [LD_W-1:0]  ld_en;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             ba_out;
    logic             inc_pc;
    logic             read;
    logic             write;
    logic [2:0]       alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic instr_t classify(input logic [31:0] op);
    case (op)
      OP_LD:                          return I_LD;
      OP_LDI:                         return I_LDI;
      OP_ST:                          return I_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return I_ALU;
      OP_MUL, OP_DIV:                 return I_MULDIV;
      OP_BR:                          return I_BR;
      OP_HALT:                        return I_HALT;
      default:                        return I_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] step_of(input state_t s);
    if ((s >= S_T0) && (s <= S_T7)) return 3'(s - S_T0);
    return 3'd0;
  endfunction

  function automatic logic is_mem_step(input state_t s, input instr_t i);
    return (s == S_T1) || ((s == S_T6) && (i == I_LD)) || ((s == S_T7) && (i == I_ST));
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: maps a step, the current opcode and the
// branch flag onto the datapath control vector for that step.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [3:0]        state,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              con_ff,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t  c;
  instr_t ins;

  assign ins  = classify(32'(opcode));
  assign ctrl = c;

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch.
    c = '0;
    case (state_t'(state))
      S_T0: begin
        c.bus_src[B_PC] = 1'b1;
        c.ld_en[L_MAR]  = 1'b1;
        c.ld_en[L_Z]    = 1'b1;
        c.inc_pc        = 1'b1;
      end
      S_T1: begin
        c.bus_src[B_ZLO] = 1'b1;
        c.ld_en[L_PC]    = 1'b1;
        c.ld_en[L_MDR]   = 1'b1;
        c.read           = 1'b1;
      end
      S_T2: begin
        c.bus_src[B_MDR] = 1'b1;
        c.ld_en[L_IR]    = 1'b1;
      end
      S_T3: begin
        case (ins)
          I_LD, I_LDI, I_ST: begin
            c.grb         = 1'b1;
            c.ba_out      = 1'b1;
            c.ld_en[L_Y]  = 1'b1;
          end
          I_ALU, I_MULDIV: begin
            c.bus_src[B_R] = 1'b1;
            c.grb          = 1'b1;
            c.ld_en[L_Y]   = 1'b1;
          end
          I_BR: begin
            c.bus_src[B_R]  = 1'b1;
            c.gra           = 1'b1;
            c.ld_en[L_CON]  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (ins)
          I_LD, I_LDI, I_ST: begin
            c.bus_src[B_C] = 1'b1;
            c.alu_op       = ALU_ADD;
            c.ld_en[L_Z]   = 1'b1;
          end
          I_ALU, I_MULDIV: begin
            c.bus_src[B_R] = 1'b1;
            c.grc          = 1'b1;
            c.alu_op       = alu_of(32'(opcode));
            c.ld_en[L_Z]   = 1'b1;
          end
          I_BR: begin
            c.bus_src[B_PC] = 1'b1;
            c.ld_en[L_Y]    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (ins)
          I_LD, I_ST: begin
            c.bus_src[B_ZLO] = 1'b1;
            c.ld_en[L_MAR]   = 1'b1;
          end
          I_LDI, I_ALU: begin
            c.bus_src[B_ZLO] = 1'b1;
            c.gra            = 1'b1;
            c.ld_en[L_R]     = 1'b1;
          end
          I_MULDIV: begin
            c.bus_src[B_ZLO] = 1'b1;
            c.ld_en[L_LO]    = 1'b1;
          end
          I_BR: begin
            c.bus_src[B_C] = 1'b1;
            c.alu_op       = ALU_ADD;
            c.ld_en[L_Z]   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (ins)
          I_ST: begin
            c.bus_src[B_R] = 1'b1;
            c.gra          = 1'b1;
            c.ld_en[L_MDR] = 1'b1;
          end
          I_LD: begin
            c.read         = 1'b1;
            c.ld_en[L_MDR] = 1'b1;
          end
          I_MULDIV: begin
            c.bus_src[B_ZHI] = 1'b1;
            c.ld_en[L_HI]    = 1'b1;
          end
          I_BR: begin
            // branch not taken still spends the step, just with no controls
            c.bus_src[B_ZLO] = con_ff;
            c.ld_en[L_PC]    = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (ins)
          I_ST: begin
            c.bus_src[B_MDR] = 1'b1;
            c.write          = 1'b1;
          end
          I_LD: begin
            c.bus_src[B_MDR] = 1'b1;
            c.gra            = 1'b1;
            c.ld_en[L_R]     = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute step sequencer with registered datapath controls,
// memory ready handshake with timeout, and sticky status flags.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int MEM_HS  = 1,
  parameter int MEM_TMO = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             con_ff,
  input  logic             mem_rdy,
  output logic [8:0]       bus_src,
  output logic [9:0]       ld_en,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             ba_out,
  output logic             inc_pc,
  output logic             read,
  output logic             write,
  output logic [2:0]       alu_op,
  output logic [2:0]       t_step,
  output logic             halted,
  output logic             mem_err,
  output logic             illegal
);

  state_t     state, state_nxt, step_end;
  instr_t     instr;
  ctrl_t      ctrl_nxt, ctrl_q;
  logic [7:0] wait_cnt;
  logic       mem_step, mem_done, timeout;

  assign instr    = classify(32'(opcode));
  assign mem_step = is_mem_step(state, instr);
  assign mem_done = (MEM_HS == 0) || mem_rdy;
  assign timeout  = (wait_cnt == 8'(MEM_TMO - 1));
  assign step_end = run ? S_T0 : S_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        case (instr)
          I_HALT:  state_nxt = S_HALTED;
          I_ILL:   state_nxt = step_end;
          default: state_nxt = S_T3;
        endcase
      end
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (instr == I_LDI || instr == I_ALU) ? step_end : S_T6;
      S_T6:   state_nxt = (instr == I_LD || instr == I_ST) ? S_T7 : step_end;
      S_T7:   state_nxt = step_end;
      default: ;
    endcase
    // a memory step overrides the normal successor until ready or timeout
    if (mem_step && !mem_done) state_nxt = timeout ? S_FAULT : state;
  end

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .state  (state_nxt),
    .opcode (opcode),
    .con_ff (con_ff),
    .ctrl   (ctrl_nxt)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ctrl_q   <= '0;
      t_step   <= '0;
      halted   <= 1'b0;
      mem_err  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_nxt;
      t_step <= step_of(state_nxt);
      if (state_nxt != state) wait_cnt <= '0;
      else if (mem_step)      wait_cnt <= wait_cnt + 8'd1;
      if (state_nxt == S_HALTED)               halted  <= 1'b1;
      if (state_nxt == S_FAULT)                mem_err <= 1'b1;
      if (state == S_T2 && instr == I_ILL)     illegal <= 1'b1;
    end
  end

  assign bus_src = ctrl_q.bus_src;
  assign ld_en   = ctrl_q.ld_en;
  assign gra     = ctrl_q.gra;
  assign grb     = ctrl_q.grb;
  assign grc     = ctrl_q.grc;
  assign ba_out  = ctrl_q.ba_out;
  assign inc_pc  = ctrl_q.inc_pc;
  assign read    = ctrl_q.read;
  assign write   = ctrl_q.write;
  assign alu_op  = ctrl_q.alu_op;

  a_bus_onehot: assert property (@(posedge clk) $onehot0(bus_src));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-instruction step tables expanded into a
// cycle-by-cycle expectation queue and compared against the outputs.
module tb_ctrl_sequencer;

  localparam int TMO = 4;

  localparam logic [8:0] BPC = 9'h001, BZLO = 9'h002, BZHI = 9'h004,
                         BMDR = 9'h008, BC = 9'h010, BR = 9'h100;
  localparam logic [9:0] LMAR = 10'h001, LPC = 10'h002, LMDR = 10'h004,
                         LIR = 10'h008, LY = 10'h010, LZ = 10'h020,
                         LHI = 10'h040, LLO = 10'h080, LR = 10'h100,
                         LCON = 10'h200;
  // flag order: gra grb grc ba_out inc_pc read write
  localparam logic [6:0] F_GRA = 7'h40, F_GRB = 7'h20, F_GRC = 7'h10,
                         F_BA = 7'h08, F_INC = 7'h04, F_RD = 7'h02,
                         F_WR = 7'h01;

  typedef struct packed {
    logic [2:0] t;
    logic [8:0] bus;
    logic [9:0] ld;
    logic [6:0] fl;
    logic [2:0] alu;
    logic [2:0] st;   // halted, mem_err, illegal
  } rec_t;

  typedef struct {
    bit run;
    int op;
    bit con;
    bit rdy;
  } stim_t;

  logic clk = 1'b0;
  logic clr, run, con_ff, mem_rdy;
  logic [4:0] opcode;

  logic [8:0] bus_src, nh_bus_src;
  logic [9:0] ld_en, nh_ld_en;
  logic gra, grb, grc, ba_out, inc_pc, read, write;
  logic nh_gra, nh_grb, nh_grc, nh_ba_out, nh_inc_pc, nh_read, nh_write;
  logic [2:0] alu_op, t_step, nh_alu_op, nh_t_step;
  logic halted, mem_err, illegal, nh_halted, nh_mem_err, nh_illegal;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPC_W(5), .MEM_HS(1), .MEM_TMO(TMO)) dut (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode), .con_ff(con_ff),
    .mem_rdy(mem_rdy), .bus_src(bus_src), .ld_en(ld_en), .gra(gra),
    .grb(grb), .grc(grc), .ba_out(ba_out), .inc_pc(inc_pc), .read(read),
    .write(write), .alu_op(alu_op), .t_step(t_step), .halted(halted),
    .mem_err(mem_err), .illegal(illegal)
  );

  ctrl_sequencer #(.OPC_W(5), .MEM_HS(0), .MEM_TMO(TMO)) dut_nh (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode), .con_ff(con_ff),
    .mem_rdy(mem_rdy), .bus_src(nh_bus_src), .ld_en(nh_ld_en), .gra(nh_gra),
    .grb(nh_grb), .grc(nh_grc), .ba_out(nh_ba_out), .inc_pc(nh_inc_pc),
    .read(nh_read), .write(nh_write), .alu_op(nh_alu_op), .t_step(nh_t_step),
    .halted(nh_halted), .mem_err(nh_mem_err), .illegal(nh_illegal)
  );

  bit   sel_nh;
  rec_t obs_now;

  always_comb begin
    if (sel_nh)
      obs_now = {nh_t_step, nh_bus_src, nh_ld_en, nh_gra, nh_grb, nh_grc,
                 nh_ba_out, nh_inc_pc, nh_read, nh_write, nh_alu_op,
                 nh_halted, nh_mem_err, nh_illegal};
    else
      obs_now = {t_step, bus_src, ld_en, gra, grb, grc, ba_out, inc_pc,
                 read, write, alu_op, halted, mem_err, illegal};
  end

  int n_checks = 0;
  int n_fail   = 0;

  rec_t  exp_q[$];
  rec_t  obs_q[$];
  stim_t stim_q[$];
  bit    m_ill, m_halt, m_err, m_hs, m_run;
  int    cur_op;
  bit    cur_con;

  // ---------------- reference model ----------------
  function automatic void push1(input int t, input logic [8:0] b, input logic [9:0] l,
                                input logic [6:0] f, input logic [2:0] a, input bit rdy);
    stim_t s;
    exp_q.push_back({3'(t), b, l, f, a, {m_halt, m_err, m_ill}});
    s.run = m_run; s.op = cur_op; s.con = cur_con; s.rdy = rdy;
    stim_q.push_back(s);
  endfunction

  // a memory step with handshake lasts d waiting cycles plus the ready cycle
  function automatic void push(input int t, input logic [8:0] b, input logic [9:0] l,
                               input logic [6:0] f, input logic [2:0] a,
                               input bit mem, input int d);
    if (!mem || !m_hs) push1(t, b, l, f, a, 1'($urandom_range(0, 1)));
    else begin
      repeat (d) push1(t, b, l, f, a, 1'b0);
      push1(t, b, l, f, a, 1'b1);
    end
  endfunction

  function automatic void reset_model();
    exp_q.delete(); stim_q.delete();
    m_ill = 0; m_halt = 0; m_err = 0; m_run = 1;
  endfunction

  function automatic void model_instr(input int op, input bit con, input int d1, input int d2);
    cur_op = op; cur_con = con;
    push(0, BPC, LMAR | LZ, F_INC, 3'd0, 0, 0);
    push(1, BZLO, LPC | LMDR, F_RD, 3'd0, 1, d1);
    push(2, BMDR, LIR, 7'h0, 3'd0, 0, 0);
    if (op == 10) return;
    if (op > 10) begin m_ill = 1; return; end
    if (op <= 2) begin
      push(3, 9'h0, LY, F_GRB | F_BA, 3'd0, 0, 0);
      push(4, BC, LZ, 7'h0, 3'd0, 0, 0);
      if (op == 1) push(5, BZLO, LR, F_GRA, 3'd0, 0, 0);
      else         push(5, BZLO, LMAR, 7'h0, 3'd0, 0, 0);
      if (op == 0) begin
        push(6, 9'h0, LMDR, F_RD, 3'd0, 1, d2);
        push(7, BMDR, LR, F_GRA, 3'd0, 0, 0);
      end else if (op == 2) begin
        push(6, BR, LMDR, F_GRA, 3'd0, 0, 0);
        push(7, BMDR, 10'h0, F_WR, 3'd0, 1, d2);
      end
    end else if (op <= 8) begin
      push(3, BR, LY, F_GRB, 3'd0, 0, 0);
      push(4, BR, LZ, F_GRC, 3'(op - 3), 0, 0);
      if (op < 7) push(5, BZLO, LR, F_GRA, 3'd0, 0, 0);
      else begin
        push(5, BZLO, LLO, 7'h0, 3'd0, 0, 0);
        push(6, BZHI, LHI, 7'h0, 3'd0, 0, 0);
      end
    end else begin
      push(3, BR, LCON, F_GRA, 3'd0, 0, 0);
      push(4, BPC, LY, 7'h0, 3'd0, 0, 0);
      push(5, BC, LZ, 7'h0, 3'd0, 0, 0);
      push(6, con ? BZLO : 9'h0, con ? LPC : 10'h0, 7'h0, 3'd0, 0, 0);
    end
  endfunction

  function automatic void model_idle(input int n);
    if (stim_q.size() > 0) stim_q[stim_q.size() - 1].run = 1'b0;
    m_run = 0;
    repeat (n) push1(0, 9'h0, 10'h0, 7'h0, 3'd0, 1'($urandom_range(0, 1)));
    m_run = 1;
  endfunction

  function automatic void model_quiet(input int n);
    repeat (n) push1(0, 9'h0, 10'h0, 7'h0, 3'd0, 1'($urandom_range(0, 1)));
  endfunction

  function automatic void model_random(input int n);
    int op;
    for (int k = 0; k < n; k++) begin
      op = int'($urandom_range(0, 11));
      if (op == 10) op = 3;
      if (op == 11) op = int'($urandom_range(11, 31));
      model_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, TMO - 1)),
                  int'($urandom_range(0, TMO - 1)));
    end
  endfunction

  // ---------------- stimulus engine ----------------
  task automatic do_reset();
    clr = 1'b0; run = 1'b0; mem_rdy = 1'b0; opcode = '0; con_ff = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    reset_model();
  endtask

  // starts from IDLE at a falling edge; records one observation per cycle
  task automatic play(input int n);
    obs_q.delete();
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      obs_q.push_back(obs_now);
      run     = stim_q[i].run;
      opcode  = 5'(stim_q[i].op);
      con_ff  = stim_q[i].con;
      mem_rdy = stim_q[i].rdy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sel_nh = (k == 1);
      #1;
      n_checks++;
      if (obs_now !== rec_t'(0)) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h expected 0", k, obs_now);
      end
    end
    sel_nh = 0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (obs_now !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL idle_no_run: got %h expected 0", obs_now);
    end
  endtask

  task automatic test_store_no_hs();
    do_reset();
    sel_nh = 1; m_hs = 0;
    model_instr(2, 0, 3, 3);
    model_instr(3, 0, 0, 0);
    model_idle(2);
    play(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL st_no_hs cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    sel_nh = 0;
  endtask

  task automatic test_load_delayed();
    int reads;
    do_reset();
    m_hs = 1;
    model_instr(0, 0, 3, 3);
    model_idle(1);
    play(exp_q.size());
    reads = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].fl[1]) reads++;
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ld_delayed cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (reads !== 8) begin
      n_fail++;
      $display("FAIL ld_read_cycles: got %0d expected 8", reads);
    end
  endtask

  task automatic test_branch();
    do_reset();
    m_hs = 1;
    model_instr(9, 0, 1, 0);
    model_instr(9, 1, 0, 0);
    model_idle(1);
    play(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    m_hs = 1; cur_op = 0; cur_con = 0;
    push(0, BPC, LMAR | LZ, F_INC, 3'd0, 0, 0);
    repeat (TMO) push1(1, BZLO, LPC | LMDR, F_RD, 3'd0, 1'b0);
    m_err = 1;
    model_quiet(6);
    play(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fault cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    clr = 1'b0;
    @(posedge clk); @(negedge clk);
    clr = 1'b1; run = 1'b0;
    n_checks++;
    if (obs_now !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL fault_clear: got %h expected 0", obs_now);
    end
  endtask

  task automatic test_clr_mid_write();
    do_reset();
    m_hs = 1;
    model_instr(2, 0, 0, 5);
    play(8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL st_pre_abort cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    clr = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (obs_now !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL clr_abort: got %h expected 0", obs_now);
    end
    clr = 1'b1; run = 1'b1;
    @(posedge clk); @(negedge clk);
    run = 1'b0;
    n_checks++;
    if (obs_now.bus !== BPC || obs_now.t !== 3'd0 || obs_now.st !== 3'b000) begin
      n_fail++;
      $display("FAIL restart_t0: got %h expected bus 001 status 0", obs_now);
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    m_hs = 1;
    model_instr(31, 0, 0, 0);
    model_instr(10, 0, 1, 0);
    m_halt = 1;
    model_quiet(5);
    play(exp_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal_halt cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      sel_nh = (k == 1); m_hs = (k == 0);
      model_random(20);
      model_idle(2);
      play(exp_q.size());
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random dut%0d cycle %0d: got %h expected %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
    sel_nh = 0;
  endtask

  initial begin
    sel_nh = 0; m_hs = 1; cur_op = 0; cur_con = 0;
    test_reset();
    test_store_no_hs();
    test_load_delayed();
    test_branch();
    test_fault();
    test_clr_mid_write();
    test_illegal_halt();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
